// File: rtl/if_fetch_unit.sv
// IF-stage instruction fetcher: owns the fetch PC, runs a single-outstanding req/ready
// handshake to instruction memory and presents one buffered instruction to IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] IFInst,
    output logic        if_valid,
    output logic        PC_IFWrite,
    output logic        IF_Flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_KILL,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;

    logic        flush;
    logic        consume;
    logic        slot_free;
    logic [31:0] target;

    assign flush     = redirect | exception;
    assign target    = exception ? EXC_PC : redirect_pc;
    assign consume   = valid_q & ~stall_if & ~flush;
    // The buffer can accept a new response at this edge if it is empty or being drained.
    assign slot_free = ~valid_q | consume;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        req_d      = req_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                req_d   = 1'b1;
                addr_d  = flush ? target : fetch_pc_q;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ready) begin
                    if (flush) begin
                        // Response arrived with a redirect: drop it and go straight to the target.
                        addr_d = target;
                    end else begin
                        inst_d     = imem_rdata;
                        pc_d       = addr_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = addr_q + 32'd4;
                        if (slot_free) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_HOLD;
                        end
                    end
                end else if (flush) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (imem_ready) begin
                    addr_d  = flush ? target : fetch_pc_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = S_REQ;
                end else if (consume) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (flush) begin
            fetch_pc_d = target;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= 32'd0;
            inst_q     <= 32'd0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign PC         = pc_q;
    assign IFInst     = inst_q;
    assign if_valid   = valid_q;
    assign PC_IFWrite = consume & reset;
    assign IF_Flush   = flush & reset;

endmodule
